pe_link_injector: RTL and testbench

//  Upstream feeder for the grid PE tiles. Takes a 32-bit valid/ready word stream and packs 4 words into one 130-bit link word.

---
 rtl/pe_link_pkg.sv | 46 ++++
 rtl/pe_sync_fifo.sv | 104 ++++++++++
 rtl/pe_link_injector.sv | 171 +++++++++++++++++
 tb/tb_pe_link_injector.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_link_pkg.sv
// pe_link_pkg: shared types and constants for the PE link injector.
//   Link word layout is {valid[129], last[128], payload[127:0]}; the FIFO
//   stores only {last, payload} because every stored entry is valid.
//   pack_lane() drops one 32-bit word into the selected lane of a pack.
package pe_link_pkg;

  localparam int LINK_VALID_BIT = 129;
  localparam int LINK_LAST_BIT  = 128;
  localparam int LINK_PAYLOAD_W = 128;
  localparam int LANES          = 4;
  localparam int LANE_IDX_W     = 2;

  localparam logic [LANE_IDX_W-1:0] LANE_FIRST = 2'd0;
  localparam logic [LANE_IDX_W-1:0] LANE_LAST  = 2'd3;
  localparam logic [LANE_IDX_W-1:0] LANE_ONE   = 2'd1;

  typedef struct packed {
    logic                      valid;
    logic                      last;
    logic [LINK_PAYLOAD_W-1:0] payload;
  } link_word_t;

  typedef struct packed {
    logic                      last;
    logic [LINK_PAYLOAD_W-1:0] payload;
  } fifo_entry_t;

  // Insert word into lane 'lane' of pack; lane 0 is payload[31:0].
  function automatic logic [LINK_PAYLOAD_W-1:0] pack_lane(
    input logic [LINK_PAYLOAD_W-1:0] pack,
    input logic [LANE_IDX_W-1:0]     lane,
    input logic [31:0]               word
  );
    logic [LINK_PAYLOAD_W-1:0] r;
    r = pack;
    case (lane)
      2'd0:    r[31:0]   = word;
      2'd1:    r[63:32]  = word;
      2'd2:    r[95:64]  = word;
      2'd3:    r[127:96] = word;
      default: r         = pack;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pe_sync_fifo.sv
// pe_sync_fifo: single-clock FIFO with registered full/empty flags and level.
//   Parameters: WIDTH (entry width), ADDR_BITS (depth = 2**ADDR_BITS).
//   Ports:
//     clk      in   clock, posedge
//     rst_n    in   asynchronous active-low reset (pointers, level, flags)
//     push_i   in   write wdata_i (ignored when full)
//     wdata_i  in   entry to write
//     pop_i    in   advance read pointer (ignored when empty)
//     rdata_o  out  head entry (combinational read of storage)
//     full_o   out  registered full flag
//     empty_o  out  registered empty flag
//     level_o  out  registered occupancy, 0..2**ADDR_BITS
//   No bypass: an entry pushed into an empty FIFO is readable one edge later.
module pe_sync_fifo #(
  parameter int WIDTH     = 129,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [ADDR_BITS:0]   level_o
);

  localparam int                   DEPTH     = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0]   LVL_FULL  = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   LVL_ONE   = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS:0]   LVL_ZERO  = (ADDR_BITS+1)'(0);
  localparam logic [ADDR_BITS-1:0] PTR_ONE   = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ZERO  = ADDR_BITS'(0);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   level_q, level_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 do_push_s, do_pop_s;

  // Next-state for pointers, level and flags; flags are derived from the
  // next level so they are registered alongside it.
  always_comb begin
    do_push_s = push_i & ~full_q;
    do_pop_s  = pop_i & ~empty_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;

    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == LVL_ZERO);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      level_q  <= LVL_ZERO;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage write; contents need no reset because empty entries are never read out.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/pe_link_injector.sv
// pe_link_injector: packs a 32-bit valid/ready word stream into 130-bit link
// words {valid, last, payload[127:0]}, buffers them in a 16-deep FIFO and
// drives them onto a downstream PE link input, advancing only under ap_start.
//   Ports:
//     clk          in   clock, posedge
//     reset        in   asynchronous active-low reset
//     ap_start     in   link advance enable shared with the downstream PE
//     in_data      in   stream word
//     in_valid     in   in_data valid
//     in_last      in   final word of a packet; flushes a partial pack
//     in_ready     out  reset & !fifo_full (from the registered full flag)
//     out_to_link  out  registered link word
//     fifo_level   out  FIFO occupancy 0..16
//   Optional build macro PE_LINK_INJECT_STATS_EN adds:
//     stat_words_sent    out  edges that emitted a valid link word (wraps)
//     stat_stall_cycles  out  edges with in_valid=1 and in_ready=0 (wraps)
module pe_link_injector
  import pe_link_pkg::*;
#(
  parameter int LINK_WIDTH     = 130,
  parameter int WORD_WIDTH     = 32,
  parameter int FIFO_ADDR_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ap_start,
  input  logic [WORD_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [LINK_WIDTH-1:0]   out_to_link,
  output logic [FIFO_ADDR_BITS:0] fifo_level
`ifdef PE_LINK_INJECT_STATS_EN
  ,
  output logic [31:0]             stat_words_sent,
  output logic [31:0]             stat_stall_cycles
`endif
);

  localparam logic [LINK_PAYLOAD_W-1:0] PAYLOAD_ZERO = {LINK_PAYLOAD_W{1'b0}};
  localparam link_word_t                LINK_IDLE    = {1'b0, 1'b0, {LINK_PAYLOAD_W{1'b0}}};

  logic [LANE_IDX_W-1:0]     lane_q, lane_d;
  logic [LINK_PAYLOAD_W-1:0] pack_q, pack_d;
  logic [LINK_PAYLOAD_W-1:0] merged_s;
  logic                      in_ready_s;
  logic                      accept_s;
  logic                      complete_s;
  fifo_entry_t               push_entry_s;
  fifo_entry_t               head_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic                      pop_s;
  link_word_t                out_q, out_d;

  // Ready never depends on in_valid, so upstream sees no combinational loop.
  assign in_ready_s = reset & ~fifo_full_s;
  assign in_ready   = in_ready_s;

  // Packer: place the accepted word in the current lane; a 4th word or
  // in_last completes the pack, pushes it and restarts at lane 0.
  always_comb begin
    accept_s     = in_valid & in_ready_s;
    merged_s     = pack_lane(pack_q, lane_q, in_data);
    complete_s   = accept_s & ((lane_q == LANE_LAST) | in_last);
    push_entry_s = {in_last, merged_s};
    lane_d       = lane_q;
    pack_d       = pack_q;
    if (complete_s) begin
      lane_d = LANE_FIRST;
      pack_d = PAYLOAD_ZERO;
    end else if (accept_s) begin
      lane_d = lane_q + LANE_ONE;
      pack_d = merged_s;
    end else begin
      lane_d = lane_q;
      pack_d = pack_q;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q <= LANE_FIRST;
      pack_q <= PAYLOAD_ZERO;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
    end
  end

  pe_sync_fifo #(
    .WIDTH     (LINK_WIDTH - 1),
    .ADDR_BITS (FIFO_ADDR_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (complete_s),
    .wdata_i (push_entry_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level)
  );

  // Output stage: with ap_start low the link word is frozen and nothing pops,
  // so the downstream PE never misses a word it was not sampling.
  always_comb begin
    pop_s = ap_start & ~fifo_empty_s;
    out_d = out_q;
    if (ap_start) begin
      if (fifo_empty_s) begin
        out_d = LINK_IDLE;
      end else begin
        out_d.valid   = 1'b1;
        out_d.last    = head_s.last;
        out_d.payload = head_s.payload;
      end
    end else begin
      out_d = out_q;
    end
  end

  // Link output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= LINK_IDLE;
    end else begin
      out_q <= out_d;
    end
  end

  assign out_to_link = out_q;

`ifdef PE_LINK_INJECT_STATS_EN
  logic [31:0] stat_words_sent_q, stat_words_sent_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // Statistics next-state; both counters wrap naturally at 32 bits.
  always_comb begin
    stat_words_sent_d = stat_words_sent_q;
    stat_stall_d      = stat_stall_q;
    if (pop_s) begin
      stat_words_sent_d = stat_words_sent_q + 32'd1;
    end else begin
      stat_words_sent_d = stat_words_sent_q;
    end
    if (in_valid & ~in_ready_s) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end else begin
      stat_stall_d = stat_stall_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_words_sent_q <= 32'd0;
      stat_stall_q      <= 32'd0;
    end else begin
      stat_words_sent_q <= stat_words_sent_d;
      stat_stall_q      <= stat_stall_d;
    end
  end

  assign stat_words_sent   = stat_words_sent_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_pe_link_injector.sv
// Self-checking bench for pe_link_injector. A queue-based reference model
// tracks the packet stream: words collect into a pack, completed packs join a
// queue of link words, and ap_start edges take from the front of that queue.
module tb_pe_link_injector;

  logic         clk = 1'b0;
  logic         reset;
  logic         ap_start;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [129:0] out_to_link;
  logic [4:0]   fifo_level;
`ifdef PE_LINK_INJECT_STATS_EN
  logic [31:0]  stat_words_sent;
  logic [31:0]  stat_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [128:0] m_fifo[$];
  logic [31:0]  m_words[$];
  logic [129:0] m_out;
  int           m_sent;
  int           m_stalls;

  pe_link_injector dut (
    .clk         (clk),
    .reset       (reset),
    .ap_start    (ap_start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_to_link (out_to_link),
    .fifo_level  (fifo_level)
`ifdef PE_LINK_INJECT_STATS_EN
    ,
    .stat_words_sent   (stat_words_sent),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_fifo.delete();
    m_words.delete();
    m_out    = 130'd0;
    m_sent   = 0;
    m_stalls = 0;
  endtask

  // Drive one cycle of inputs (called at posedge+1), advance the model across
  // the next posedge, and return at posedge+1.
  task automatic step(input logic v, input logic [31:0] d, input logic l, input logic ap);
    logic         acc;
    logic [127:0] p;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    ap_start = ap;
    acc = v && (m_fifo.size() < 16);
    if (v && !acc) m_stalls++;
    @(posedge clk);
    if (ap) begin
      if (m_fifo.size() > 0) begin
        m_out = {1'b1, m_fifo.pop_front()};
        m_sent++;
      end else begin
        m_out = 130'd0;
      end
    end
    if (acc) begin
      m_words.push_back(d);
      if (m_words.size() == 4 || l) begin
        p = 128'd0;
        foreach (m_words[i]) p[i*32 +: 32] = m_words[i];
        m_fifo.push_back({l, p});
        m_words.delete();
      end
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    ap_start = 1'b0;
    reset    = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 32'd0;
    ap_start = 1'b0;
    reset    = 1'b0;
    model_clear();
    #1;
    checks++; if (out_to_link !== 130'd0) begin errors++; $display("FAIL reset_out got %h exp 0", out_to_link); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", in_ready); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", in_ready); end
    checks++; if (out_to_link !== 130'd0 || fifo_level !== 5'd0) begin errors++; $display("FAIL release_state got %h/%0d exp 0/0", out_to_link, fifo_level); end
  endtask

  task automatic test_basic();
    step(1'b1, 32'h11, 1'b0, 1'b1);
    step(1'b1, 32'h22, 1'b0, 1'b1);
    step(1'b1, 32'h33, 1'b0, 1'b1);
    step(1'b1, 32'h44, 1'b1, 1'b1);
    checks++; if (out_to_link !== 130'd0 || fifo_level !== 5'd1) begin errors++; $display("FAIL basic_push got %h/%0d exp 0/1", out_to_link, fifo_level); end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (out_to_link !== 130'h3_00000044_00000033_00000022_00000011) begin errors++; $display("FAIL basic_out got %h exp 3_00000044_00000033_00000022_00000011", out_to_link); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL basic_level got %0d exp 0", fifo_level); end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (out_to_link !== 130'd0) begin errors++; $display("FAIL basic_idle got %h exp 0", out_to_link); end
  endtask

  task automatic test_partial();
    step(1'b1, 32'hA, 1'b0, 1'b1);
    step(1'b1, 32'hB, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (out_to_link !== 130'h3_00000000_00000000_0000000B_0000000A) begin errors++; $display("FAIL partial_out got %h exp 3_00000000_00000000_0000000B_0000000A", out_to_link); end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (out_to_link !== 130'd0) begin errors++; $display("FAIL partial_idle got %h exp 0", out_to_link); end
  endtask

  task automatic test_full();
    logic [31:0]  base;
    logic [129:0] exp;
    logic [129:0] held;
    base = $urandom;
    held = 130'h3_00000000_00000000_00000000_C0DE0001;
    step(1'b1, 32'hC0DE0001, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (out_to_link !== held) begin errors++; $display("FAIL full_pre got %h exp %h", out_to_link, held); end
    for (int i = 0; i < 64; i++) begin
      step(1'b1, base + i, (i % 4) == 3, 1'b0);
      checks++; if (in_ready !== (i < 63)) begin errors++; $display("FAIL full_fill_ready i=%0d got %b exp %b", i, in_ready, (i < 63)); end
    end
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_level got %0d exp 16", fifo_level); end
    for (int s = 0; s < 3; s++) begin
      step(1'b1, 32'hDEAD0065, 1'b1, 1'b0);
      checks++; if (in_ready !== 1'b0 || fifo_level !== 5'd16) begin errors++; $display("FAIL full_stall got %b/%0d exp 0/16", in_ready, fifo_level); end
      checks++; if (out_to_link !== held) begin errors++; $display("FAIL full_hold got %h exp %h", out_to_link, held); end
    end
    for (int k = 0; k < 16; k++) begin
      step(k < 2, 32'hDEAD0065, 1'b1, 1'b1);
      exp = {2'b11, base + 32'(4*k+3), base + 32'(4*k+2), base + 32'(4*k+1), base + 32'(4*k)};
      checks++; if (out_to_link !== exp) begin errors++; $display("FAIL full_drain k=%0d got %h exp %h", k, out_to_link, exp); end
      if (k == 0) begin
        checks++; if (in_ready !== 1'b1 || fifo_level !== 5'd15) begin errors++; $display("FAIL full_first_pop got %b/%0d exp 1/15", in_ready, fifo_level); end
      end
    end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (out_to_link !== 130'h3_00000000_00000000_00000000_DEAD0065) begin errors++; $display("FAIL full_tail got %h exp 3_..._DEAD0065", out_to_link); end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (out_to_link !== 130'd0 || fifo_level !== 5'd0) begin errors++; $display("FAIL full_empty got %h/%0d exp 0/0", out_to_link, fifo_level); end
  endtask

  task automatic test_toggle();
    logic [129:0] packs[3];
    logic [31:0]  w[4];
    logic [129:0] prev;
    logic [129:0] exp;
    int           idx;
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < 4; j++) begin
        w[j] = $urandom;
        step(1'b1, w[j], j == 3, 1'b0);
      end
      packs[p] = {2'b11, w[3], w[2], w[1], w[0]};
    end
    prev = 130'd0;
    idx  = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 32'h0, 1'b0, (c % 2) == 0);
      if ((c % 2) == 0) begin
        exp = (idx < 3) ? packs[idx] : 130'd0;
        idx++;
      end else begin
        exp = prev;
      end
      checks++; if (out_to_link !== exp) begin errors++; $display("FAIL toggle c=%0d got %h exp %h", c, out_to_link, exp); end
      prev = exp;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0]  w[4];
    logic [129:0] exp;
    for (int i = 0; i < 24; i++) step(1'b1, $urandom, (i % 4) == 3, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (fifo_level !== 5'd5 || out_to_link[129] !== 1'b1) begin errors++; $display("FAIL mid_pre got lvl %0d v %b exp 5/1", fifo_level, out_to_link[129]); end
    step(1'b1, 32'h1234, 1'b0, 1'b0);
    step(1'b1, 32'h5678, 1'b0, 1'b0);
    reset = 1'b0;
    model_clear();
    #1;
    checks++; if (out_to_link !== 130'd0 || fifo_level !== 5'd0) begin errors++; $display("FAIL mid_async got %h/%0d exp 0/0", out_to_link, fifo_level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b exp 0", in_ready); end
    in_valid = 1'b0;
    ap_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) begin
      w[j] = $urandom;
      step(1'b1, w[j], j == 3, 1'b1);
    end
    step(1'b0, 32'h0, 1'b0, 1'b1);
    exp = {2'b11, w[3], w[2], w[1], w[0]};
    checks++; if (out_to_link !== exp) begin errors++; $display("FAIL mid_after got %h exp %h", out_to_link, exp); end
  endtask

  task automatic test_random();
    logic v, l, ap;
    for (int c = 0; c < 420; c++) begin
      v  = $urandom_range(0, 3) != 0;
      l  = $urandom_range(0, 5) == 0;
      ap = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if (c >= 400) begin v = 1'b0; ap = 1'b1; end
      step(v, $urandom, l, ap);
      checks++; if (out_to_link !== m_out) begin errors++; $display("FAIL rand_out c=%0d got %h exp %h", c, out_to_link, m_out); end
      checks++; if (fifo_level !== 5'(m_fifo.size())) begin errors++; $display("FAIL rand_level c=%0d got %0d exp %0d", c, fifo_level, m_fifo.size()); end
      checks++; if (in_ready !== (m_fifo.size() < 16)) begin errors++; $display("FAIL rand_ready c=%0d got %b exp %b", c, in_ready, (m_fifo.size() < 16)); end
    end
  endtask

`ifdef PE_LINK_INJECT_STATS_EN
  task automatic test_stats();
    do_reset();
    checks++; if (stat_words_sent !== 32'd0 || stat_stall_cycles !== 32'd0) begin errors++; $display("FAIL stats_reset got %0d/%0d exp 0/0", stat_words_sent, stat_stall_cycles); end
    for (int i = 0; i < 64; i++) step(1'b1, $urandom, (i % 4) == 3, 1'b0);
    for (int s = 0; s < 3; s++) step(1'b1, 32'h99, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (stat_words_sent !== 32'd16 || m_sent != 16) begin errors++; $display("FAIL stats_sent got %0d exp 16", stat_words_sent); end
    checks++; if (stat_stall_cycles !== 32'd3 || m_stalls != 3) begin errors++; $display("FAIL stats_stall got %0d exp 3", stat_stall_cycles); end
    step(1'b1, 32'h5, 1'b1, 1'b0);
    force dut.stat_words_sent_q = 32'hFFFFFFFF;
    #1;
    release dut.stat_words_sent_q;
    step(1'b0, 32'h0, 1'b0, 1'b1);
    checks++; if (stat_words_sent !== 32'd0) begin errors++; $display("FAIL stats_wrap got %h exp 0", stat_words_sent); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_full();
    test_toggle();
    test_reset_mid();
    test_random();
`ifdef PE_LINK_INJECT_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
